// File: rtl/thread_switch_trigger_pkg.sv
// Shared definitions for the thread-switch trigger and the thread controller.
package thread_switch_trigger_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_HALT   = 2'd3
  } tst_state_t;

  // Resume PCs loaded into the table at reset; the thread controller boots from these too.
  localparam logic [31:0] THREAD0_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] THREAD1_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/thread_switch_trigger_resume_table.sv
// Two-entry per-thread table: resume PC, terminated flag and miss-pending flag.
// One write port driven by the trigger logic, one read port indexed by the switch target.
module thread_resume_table
  import thread_switch_trigger_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,        // miss switch: save PC, mark pending
  input  logic                  i_wr_idx,       // thread being switched out
  input  logic [ADDR_WIDTH-1:0] i_wr_pc,
  input  logic                  i_set_done,     // thread i_wr_idx has terminated
  input  logic                  i_clr_pending,  // parked thread's miss has returned
  input  logic                  i_clr_idx,
  input  logic                  i_rd_idx,
  output logic [ADDR_WIDTH-1:0] o_rd_pc,
  output logic [1:0]            o_done,
  output logic [1:0]            o_pending
);

  logic [ADDR_WIDTH-1:0] r_pc [2];
  logic [1:0]            r_done;
  logic [1:0]            r_pending;

  // Resume PC storage; a miss switch replays the missing load, so its PC is saved.
  // NOTE: this storage is reset (unlike a RAM) because both entries must hold boot PCs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state always uses non-blocking assignment to avoid update races.
      r_pc[0] <= ADDR_WIDTH'(THREAD0_RESET_PC);
      r_pc[1] <= ADDR_WIDTH'(THREAD1_RESET_PC);
    end else if (i_wr_en) begin
      r_pc[i_wr_idx] <= i_wr_pc;
    end
  end

  // Done and pending flags; a set on the current thread coexists with a clear on the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= '0;
      r_pending <= '0;
    end else begin
      if (i_set_done)    r_done[i_wr_idx]     <= 1'b1;
      if (i_clr_pending) r_pending[i_clr_idx] <= 1'b0;
      if (i_wr_en)       r_pending[i_wr_idx]  <= 1'b1;
    end
  end

  assign o_rd_pc   = r_pc[i_rd_idx];
  assign o_done    = r_done;
  assign o_pending = r_pending;

endmodule

// File: rtl/thread_switch_trigger.sv
// Watches MEM for load misses and thread termination, drains IF..EX, then
// issues a one-cycle switch request with the target thread and its resume PC.
module thread_switch_trigger
  import thread_switch_trigger_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MIN_RUN_CYCLES = 16,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic                  mem_is_load,
  input  logic                  mem_miss,
  input  logic [ADDR_WIDTH-1:0] mem_pc,
  input  logic                  thread_done,
  input  logic                  miss_done,
  output logic                  flush,
  output logic                  stall,
  output logic                  switch_valid,
  output logic                  switch_thread,
  output logic [ADDR_WIDTH-1:0] switch_pc,
  output logic                  cur_thread,
  output logic                  all_done
);

  localparam int RUN_CNT_W   = $clog2(MIN_RUN_CYCLES + 1);
  localparam int DRAIN_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [RUN_CNT_W-1:0]   RUN_SAT    = RUN_CNT_W'(MIN_RUN_CYCLES);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  tst_state_t             r_state;
  logic                   r_cur;
  logic                   r_target;
  logic [RUN_CNT_W-1:0]   r_run_cnt;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt;
  logic                   r_flush;
  logic                   r_stall;
  logic                   r_switch_valid;
  logic                   r_switch_thread;
  logic [ADDR_WIDTH-1:0]  r_switch_pc;
  logic                   r_all_done;

  logic                   w_other;
  logic                   w_other_live;
  logic                   w_done_trig;
  logic                   w_miss_trig;
  logic [1:0]             w_done;
  logic [1:0]             w_pending;
  logic [ADDR_WIDTH-1:0]  w_target_pc;

  assign w_other      = ~r_cur;
  assign w_other_live = !w_done[w_other] && !w_pending[w_other];
  // Termination outranks a miss in the same cycle, so that miss never marks pending.
  assign w_done_trig  = (r_state == ST_RUN) && mem_valid && thread_done;
  assign w_miss_trig  = (r_state == ST_RUN) && !w_done_trig && mem_valid && mem_is_load &&
                        mem_miss && (r_run_cnt == RUN_SAT) && w_other_live;

  thread_resume_table #(.ADDR_WIDTH(ADDR_WIDTH)) u_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_en      (w_miss_trig),
    .i_wr_idx     (r_cur),
    .i_wr_pc      (mem_pc),
    .i_set_done   (w_done_trig),
    .i_clr_pending(miss_done),
    .i_clr_idx    (w_other),
    .i_rd_idx     (r_target),
    .o_rd_pc      (w_target_pc),
    .o_done       (w_done),
    .o_pending    (w_pending)
  );

  // Switch sequencer: RUN -> DRAIN -> SWITCH -> RUN, or RUN -> HALT once both threads end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_RUN;
      r_cur           <= 1'b0;
      r_target        <= 1'b0;
      r_run_cnt       <= '0;
      r_drain_cnt     <= '0;
      r_flush         <= 1'b0;
      r_stall         <= 1'b0;
      r_switch_valid  <= 1'b0;
      r_switch_thread <= 1'b0;
      r_switch_pc     <= '0;
      r_all_done      <= 1'b0;
    end else begin
      r_switch_valid  <= 1'b0;
      r_switch_thread <= 1'b0;
      r_switch_pc     <= '0;
      unique case (r_state)
        ST_RUN: begin
          if (r_run_cnt != RUN_SAT) r_run_cnt <= r_run_cnt + 1'b1;
          if (w_done_trig && w_done[w_other]) begin
            r_state    <= ST_HALT;
            r_all_done <= 1'b1;
            r_stall    <= 1'b1;
          end else if (w_done_trig || w_miss_trig) begin
            r_state     <= ST_DRAIN;
            r_target    <= w_other;
            r_drain_cnt <= DRAIN_LOAD;
            r_flush     <= 1'b1;
            r_stall     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state         <= ST_SWITCH;
            r_flush         <= 1'b0;
            r_switch_valid  <= 1'b1;
            r_switch_thread <= r_target;
            r_switch_pc     <= w_target_pc;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        ST_SWITCH: begin
          r_state   <= ST_RUN;
          r_cur     <= r_target;
          r_run_cnt <= '0;
          r_stall   <= 1'b0;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign flush         = r_flush;
  assign stall         = r_stall;
  assign switch_valid  = r_switch_valid;
  assign switch_thread = r_switch_thread;
  assign switch_pc     = r_switch_pc;
  assign cur_thread    = r_cur;
  assign all_done      = r_all_done;

endmodule
